// File: rtl/ir_nec_pkg.sv
// Shared types and NEC protocol unit constants for the IR transmitter.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_STOP_MARK  = 3'd5,
    S_GAP        = 3'd6
  } state_t;

  localparam int unsigned LEAD_MARK_U  = 16;
  localparam int unsigned LEAD_SPACE_U = 8;
  localparam int unsigned REP_SPACE_U  = 4;
  localparam int unsigned ONE_SPACE_U  = 3;
  localparam int unsigned BIT_U        = 1;
  localparam int unsigned NEC_BITS     = 32;

  // States in which the LED envelope is on.
  function automatic logic is_mark(state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier divider for the IR LED. carrier_nx is the carrier level that
// applies to the cycle following the current edge, so the caller can register
// it alongside the envelope and keep both outputs aligned.
module ir_carrier_gen #(
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 438
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic carrier_nx
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  // Next count: restart forces phase 0 so each mark opens with a high phase.
  always_comb begin
    cnt_nx = cnt + 1'b1;
    if (restart || (cnt == CW'(CARRIER_DIV - 1))) begin
      cnt_nx = '0;
    end
    carrier_nx = ({{(32-CW){1'b0}}, cnt_nx} < 32'(CARRIER_HIGH));
  end

  // Carrier phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nx;
    end
  end

endmodule

// File: rtl/ir_nec_transmit.sv
// NEC infrared transmitter: accepts a 32-bit frame or a repeat request via
// valid/ready and emits the carrier-modulated mark/space train, LSB first.
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | ready, waiting for iVALID
// S_LEAD_MARK  | 16-unit leader mark
// S_LEAD_SPACE | 8-unit leader space (4 units for a repeat code)
// S_BIT_MARK   | 1-unit mark opening each data bit
// S_BIT_SPACE  | 1-unit (bit=0) or 3-unit (bit=1) space closing each bit
// S_STOP_MARK  | 1-unit trailing mark
// S_GAP        | GAP_UNITS of silence before returning to idle
module ir_nec_transmit
  import ir_nec_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 28125,
  parameter int CARRIER_DIV    = 1316,
  parameter int CARRIER_HIGH   = 438,
  parameter int GAP_UNITS      = 72
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iVALID,
  input  logic        iREPEAT,
  input  logic [31:0] iDATA,
  output logic        oREADY,
  output logic        oIRDA,
  output logic        oENVELOPE,
  output logic        oDONE
);

  localparam int TW      = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int DUR_MAX = (GAP_UNITS > int'(LEAD_MARK_U)) ? GAP_UNITS : int'(LEAD_MARK_U);
  localparam int DW      = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

  state_t        state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [DW-1:0] dur, dur_nx, len_m1;
  logic [4:0]    bit_idx, bit_idx_nx;
  logic [31:0]   data_q;
  logic          rep_q;
  logic          accept, unit_end, state_end, done_nx;
  logic          restart, carrier_nx, mark_nx;

  assign oREADY  = (state == S_IDLE);
  assign accept  = oREADY && iVALID;
  assign mark_nx = is_mark(state_nx);
  assign restart = mark_nx && !is_mark(state);

  ir_carrier_gen #(
    .CARRIER_DIV  (CARRIER_DIV),
    .CARRIER_HIGH (CARRIER_HIGH)
  ) u_carrier (
    .clk        (iCLK),
    .rst_n      (iRST_n),
    .restart    (restart),
    .carrier_nx (carrier_nx)
  );

  // Next-state logic: unit timer wraps drive the per-state unit count.
  always_comb begin
    state_nx   = state;
    tick_nx    = tick;
    dur_nx     = dur;
    bit_idx_nx = bit_idx;
    done_nx    = 1'b0;
    len_m1     = '0;

    case (state)
      S_LEAD_MARK:  len_m1 = DW'(LEAD_MARK_U - 1);
      S_LEAD_SPACE: len_m1 = rep_q ? DW'(REP_SPACE_U - 1) : DW'(LEAD_SPACE_U - 1);
      S_BIT_MARK:   len_m1 = DW'(BIT_U - 1);
      S_BIT_SPACE:  len_m1 = data_q[bit_idx] ? DW'(ONE_SPACE_U - 1) : DW'(BIT_U - 1);
      S_STOP_MARK:  len_m1 = DW'(BIT_U - 1);
      S_GAP:        len_m1 = DW'(GAP_UNITS - 1);
      default:      len_m1 = '0;
    endcase

    unit_end  = (tick == TW'(TICKS_PER_UNIT - 1));
    state_end = unit_end && (dur == len_m1);

    if (state == S_IDLE) begin
      tick_nx    = '0;
      dur_nx     = '0;
      bit_idx_nx = '0;
      if (accept) begin
        state_nx = S_LEAD_MARK;
      end
    end else begin
      tick_nx = unit_end ? '0 : tick + 1'b1;
      if (unit_end) begin
        dur_nx = state_end ? '0 : dur + 1'b1;
      end
      if (state_end) begin
        case (state)
          S_LEAD_MARK:  state_nx = S_LEAD_SPACE;
          S_LEAD_SPACE: state_nx = rep_q ? S_STOP_MARK : S_BIT_MARK;
          S_BIT_MARK:   state_nx = S_BIT_SPACE;
          S_BIT_SPACE: begin
            if (bit_idx == 5'(NEC_BITS - 1)) begin
              state_nx = S_STOP_MARK;
            end else begin
              bit_idx_nx = bit_idx + 1'b1;
              state_nx   = S_BIT_MARK;
            end
          end
          S_STOP_MARK:  state_nx = S_GAP;
          S_GAP: begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
          default:      state_nx = S_IDLE;
        endcase
      end
    end
  end

  // State, counters and the frame latched at the handshake.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= S_IDLE;
      tick    <= '0;
      dur     <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      rep_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      tick    <= tick_nx;
      dur     <= dur_nx;
      bit_idx <= bit_idx_nx;
      if (accept) begin
        data_q <= iDATA;
        rep_q  <= iREPEAT;
      end
    end
  end

  // Registered outputs, computed from the next state so they line up with it.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oENVELOPE <= 1'b0;
      oIRDA     <= 1'b0;
      oDONE     <= 1'b0;
    end else begin
      oENVELOPE <= mark_nx;
      oIRDA     <= mark_nx && carrier_nx;
      oDONE     <= done_nx;
    end
  end

endmodule

// File: tb/tb_ir_nec_transmit.sv
// Bench for ir_nec_transmit: scaled-down timing, reference waveform built
// from the protocol's segment list and compared cycle by cycle.
module tb_ir_nec_transmit;

  localparam int TPU  = 20;
  localparam int DIV  = 7;
  localparam int HI   = 3;
  localparam int GAPU = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        rep = 1'b0;
  logic [31:0] data = '0;
  logic        ready, irda, env, done;

  int total = 0;
  int bad   = 0;

  bit exp_env[$];
  bit exp_irda[$];

  always #5 clk = ~clk;

  ir_nec_transmit #(
    .TICKS_PER_UNIT (TPU),
    .CARRIER_DIV    (DIV),
    .CARRIER_HIGH   (HI),
    .GAP_UNITS      (GAPU)
  ) dut (
    .iCLK      (clk),
    .iRST_n    (rst_n),
    .iVALID    (valid),
    .iREPEAT   (rep),
    .iDATA     (data),
    .oREADY    (ready),
    .oIRDA     (irda),
    .oENVELOPE (env),
    .oDONE     (done)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_seg(input bit lvl, input int units);
    for (int i = 0; i < units * TPU; i++) begin
      exp_env.push_back(lvl);
      exp_irda.push_back(lvl && ((i % DIV) < HI));
    end
  endtask

  task automatic build(input logic [31:0] d, input bit r);
    exp_env.delete();
    exp_irda.delete();
    push_seg(1'b1, 16);
    push_seg(1'b0, r ? 4 : 8);
    if (!r) begin
      for (int b = 0; b < 32; b++) begin
        push_seg(1'b1, 1);
        push_seg(1'b0, d[b] ? 3 : 1);
      end
    end
    push_seg(1'b1, 1);
    push_seg(1'b0, GAPU);
  endtask

  // Called at a negedge; returns at the negedge of frame cycle 0.
  task automatic start_frame(input logic [31:0] d, input bit r);
    int w = 0;
    while (ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_send", ready, 1);
    valid = 1'b1;
    data  = d;
    rep   = r;
    @(negedge clk);
    valid = 1'b0;
    data  = ~d;
    rep   = ~r;
  endtask

  task automatic check_frame(input logic [31:0] d, input bit r, input bit noise,
                             input bit chain, input logic [31:0] cd, input bit cr);
    int L, e_env, e_irda, e_rdy, e_done, highs;
    build(d, r);
    L = exp_env.size();
    e_env = 0; e_irda = 0; e_rdy = 0; e_done = 0; highs = 0;
    check("first_mark_irda", irda, 1);
    for (int j = 0; j < L; j++) begin
      if (j > 0) @(negedge clk);
      if (env !== exp_env[j])   e_env++;
      if (irda !== exp_irda[j]) e_irda++;
      if (ready !== 1'b0)       e_rdy++;
      if (done !== 1'b0)        e_done++;
      if (env === 1'b1)         highs++;
      if (noise && j == 10) begin
        valid = 1'b1;
        data  = $urandom;
        rep   = 1'($urandom_range(0, 1));
      end
      if (noise && j == L / 2) valid = 1'b0;
      if (chain && j == L - 3) begin
        valid = 1'b1;
        data  = cd;
        rep   = cr;
      end
    end
    @(negedge clk);
    check("envelope_cycles_wrong", e_env, 0);
    check("irda_cycles_wrong", e_irda, 0);
    check("ready_while_busy", e_rdy, 0);
    check("done_early", e_done, 0);
    check("mark_cycle_total", highs, TPU * (r ? 17 : 49));
    check("done_pulse", done, 1);
    check("ready_at_done", ready, 1);
    check("env_at_done", env, 0);
    @(negedge clk);
    if (chain) begin
      valid = 1'b0;
    end else begin
      check("done_cleared", done, 0);
      check("ready_idle", ready, 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    bit          r;
    int          e_idle, units;

    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_irda", irda, 0);
    check("reset_env", env, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;

    e_idle = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready !== 1'b1 || irda !== 1'b0 || env !== 1'b0 || done !== 1'b0) e_idle++;
    end
    check("idle_quiet", e_idle, 0);

    d = 32'hFD02_FF00;
    start_frame(d, 1'b0);
    check_frame(d, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    d = $urandom;
    start_frame(d, 1'b1);
    check_frame(d, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    d = $urandom;
    start_frame(d, 1'b0);
    check_frame(d, 1'b0, 1'b1, 1'b0, '0, 1'b0);

    d  = $urandom;
    d2 = $urandom;
    start_frame(d, 1'b0);
    check_frame(d, 1'b0, 1'b0, 1'b1, d2, 1'b1);
    check_frame(d2, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      r = ($urandom_range(0, 3) == 0);
      start_frame(d, r);
      check_frame(d, r, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
    end

    d = $urandom | 32'h0000_0400;
    start_frame(d, 1'b0);
    units = 24 + 1;
    for (int b = 0; b < 10; b++) units += 2 + (d[b] ? 2 : 0);
    repeat (units * TPU + TPU) @(negedge clk);
    check("pre_reset_space", env, 0);
    check("pre_reset_busy", ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_env", env, 0);
    check("abort_irda", irda, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_env", env, 0);
    check("post_reset_ready", ready, 1);
    d = $urandom;
    start_frame(d, 1'b0);
    check_frame(d, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
